// File: rtl/ip_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : ip_byte_packer
// Purpose  : Packs a byte-wide IPv4 packet stream big-endian into 32-bit words
//            held in an internal packet buffer. Once the whole packet is
//            stored, it replays the packet as a gap-free burst of one word per
//            cycle, with a one-cycle start pulse on word 0. Packets longer than
//            4*DEPTH_WORDS bytes are discarded and flagged with a drop pulse.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous active-low reset
//            in_data    - packet byte
//            in_valid   - byte qualifier (accepted when in_valid && in_ready)
//            in_sof     - first byte of packet
//            in_eof     - last byte of packet
//            in_ready   - high in IDLE and FILL, low in SEND
//            data       - replayed word, first byte of each group in [31:24]
//            start      - one-cycle pulse with word 0
//            word_valid - high on every cycle data holds a packet word
//            len_words  - word count of the packet being / last replayed
//            busy       - high in FILL and SEND
//            drop       - one-cycle pulse when an overflowed packet is dropped
// Revision : 1.0 - initial release
// ============================================================================
module ip_byte_packer #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic          in_eof,
  output logic          in_ready,
  output logic [31:0]   data,
  output logic          start,
  output logic          word_valid,
  output logic [AW:0]   len_words,
  output logic          busy,
  output logic          drop
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;       // next lane to fill: 3,2,1,0 then wraps
  logic [AW:0] widx_q, widx_d;       // word write index
  logic [AW:0] len_q, len_d;
  logic [AW:0] raddr_q, raddr_d;     // replay read address
  logic [31:0] acc_q, acc_d;         // word accumulator (lanes above lane_q)
  logic        ovf_q, ovf_d;
  logic        start_q, start_d;
  logic        wv_q, wv_d;
  logic        drop_q, drop_d;
  logic [31:0] data_q;

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;
  logic          w_re;
  logic          w_accept;
  logic [31:0]   w_merged;

  // Packet buffer; deliberately not reset so contents survive a reset.
  logic [31:0] mem [DEPTH_WORDS];

  assign in_ready   = (state_q != SEND);
  assign busy       = (state_q != IDLE);
  assign w_accept   = in_valid && in_ready;
  // Lanes below lane_q are still zero, so OR-ing in the byte also yields
  // the zero-padded partial word needed at end of packet.
  assign w_merged   = acc_q | ({24'h0, in_data} << {lane_q, 3'b000});

  assign data       = data_q;
  assign start      = start_q;
  assign word_valid = wv_q;
  assign len_words  = len_q;
  assign drop       = drop_q;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    widx_d  = widx_q;
    len_d   = len_q;
    raddr_d = raddr_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    start_d = 1'b0;
    wv_d    = 1'b0;
    drop_d  = 1'b0;
    w_we    = 1'b0;
    w_waddr = widx_q[AW-1:0];
    w_wdata = w_merged;
    w_re    = 1'b0;

    case (state_q)
      IDLE, FILL: begin
        if (w_accept) begin
          if (in_sof) begin
            // A start byte always begins a fresh packet, abandoning any
            // partial one that was being filled.
            ovf_d  = 1'b0;
            widx_d = '0;
            lane_d = 2'd2;
            acc_d  = {in_data, 24'h0};
            if (in_eof) begin
              w_we    = 1'b1;
              w_waddr = '0;
              w_wdata = {in_data, 24'h0};
              len_d   = (AW+1)'(1);
              raddr_d = '0;
              state_d = SEND;
            end else begin
              state_d = FILL;
            end
          end else if (state_q == FILL) begin
            lane_d = lane_q - 2'd1;
            acc_d  = w_merged;
            if (in_eof || (lane_q == 2'd0)) begin
              acc_d  = '0;
              lane_d = 2'd3;
              if (!ovf_q) begin
                if (widx_q == c_DEPTH) begin
                  ovf_d = 1'b1;
                end else begin
                  w_we   = 1'b1;
                  widx_d = widx_q + 1'b1;
                end
              end
            end
            if (in_eof) begin
              if (ovf_d) begin
                drop_d  = 1'b1;
                ovf_d   = 1'b0;
                state_d = IDLE;
              end else begin
                len_d   = widx_q + 1'b1;
                raddr_d = '0;
                state_d = SEND;
              end
            end
          end
        end
      end
      SEND: begin
        // One extra SEND cycle after the last read keeps in_ready low while
        // the final word is still on the output.
        if (raddr_q < len_q) begin
          w_re    = 1'b1;
          raddr_d = raddr_q + 1'b1;
          wv_d    = 1'b1;
          start_d = (raddr_q == '0);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      widx_q  <= '0;
      len_q   <= '0;
      raddr_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      start_q <= 1'b0;
      wv_q    <= 1'b0;
      drop_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      widx_q  <= widx_d;
      len_q   <= len_d;
      raddr_q <= raddr_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      start_q <= start_d;
      wv_q    <= wv_d;
      drop_q  <= drop_d;
      if (w_re) begin
        data_q <= mem[raddr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      mem[w_waddr] <= w_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ip_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_byte_packer
// Purpose  : Self-checking bench for ip_byte_packer. Expected replay words
//            (with their expected cycle and start flag) are queued when a
//            packet is driven and popped by a monitor as words appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_byte_packer;

  localparam int DEPTH_WORDS = 8;
  localparam int AW          = 3;

  logic          clk;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_sof;
  logic          in_eof;
  logic          in_ready;
  logic [31:0]   data;
  logic          start;
  logic          word_valid;
  logic [AW:0]   len_words;
  logic          busy;
  logic          drop;

  ip_byte_packer #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_eof    (in_eof),
    .in_ready  (in_ready),
    .data      (data),
    .start     (start),
    .word_valid(word_valid),
    .len_words (len_words),
    .busy      (busy),
    .drop      (drop)
  );

  typedef struct {
    int          at;
    logic        st;
    logic [31:0] word;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       m_e;
  logic [7:0] pkt[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         e;
  int         last_len;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Scoreboard monitor: every word seen must be the next expected one.
  always @(negedge clk) begin
    if (word_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {32'h0, data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        m_e = exp_q.pop_front();
        chk("word_data", {32'h0, data}, {32'h0, m_e.word});
        chk("word_start", {63'h0, start}, {63'h0, m_e.st});
        chk("word_cycle", 64'(cyc), 64'(m_e.at));
      end
    end else if (start) begin
      chk("start_without_valid", {63'h0, start}, 64'h0);
    end
  end

  // Entered mid-cycle; returns mid-cycle E+1 with eo = E (cycle of last byte).
  task automatic drive_pkt(input bit with_eof, output int eo);
    for (int i = 0; i < pkt.size(); i++) begin
      int guard;
      guard = 0;
      while (!in_ready && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!in_ready) chk("ready_timeout", {63'h0, in_ready}, 64'h1);
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_sof   = (i == 0);
      in_eof   = with_eof && (i == pkt.size() - 1);
      eo       = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
  endtask

  task automatic push_exp(input int eo, input int nmax);
    int          n;
    logic [31:0] w;
    exp_t        t;
    n = (pkt.size() + 3) / 4;
    for (int k = 0; k < n && k < nmax; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4*k + j < pkt.size()) w[31-8*j -: 8] = pkt[4*k + j];
      t.at   = eo + 2 + k;
      t.st   = (k == 0);
      t.word = w;
      exp_q.push_back(t);
    end
  endtask

  // Called mid-cycle E+1; returns at the falling edge of cycle E+2+N.
  task automatic check_replay(input int n);
    @(negedge clk);
    chk("len_words", 64'(len_words), 64'(n));
    chk("drop_quiet", {63'h0, drop}, 64'h0);
    chk("busy_send", {63'h0, busy}, 64'h1);
    chk("ready_low_send", {63'h0, in_ready}, 64'h0);
    repeat (n) @(negedge clk);
    chk("ready_low_last", {63'h0, in_ready}, 64'h0);
    @(negedge clk);
    chk("ready_back", {63'h0, in_ready}, 64'h1);
    chk("busy_done", {63'h0, busy}, 64'h0);
    chk("valid_done", {63'h0, word_valid}, 64'h0);
  endtask

  task automatic make_pkt(input int nbytes, input logic [7:0] seed);
    pkt.delete();
    for (int i = 0; i < nbytes; i++) pkt.push_back(8'(seed + 8'(i * 7)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eof   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {32'h0, data}, 64'h0);
    chk("rst_start", {63'h0, start}, 64'h0);
    chk("rst_valid", {63'h0, word_valid}, 64'h0);
    chk("rst_drop", {63'h0, drop}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_len", 64'(len_words), 64'h0);
    chk("rst_ready", {63'h0, in_ready}, 64'h1);
    reset = 1'b1;
    @(posedge clk); #1;

    // 20-byte IPv4 header
    pkt = '{8'h45, 8'h00, 8'h00, 8'h14, 8'h00, 8'h01, 8'h40, 8'h00, 8'h40, 8'h06,
            8'h00, 8'h00, 8'h0a, 8'h00, 8'h00, 8'h01, 8'h0a, 8'h00, 8'h00, 8'h02};
    drive_pkt(1'b1, e);
    push_exp(e, 99);
    check_replay(5);

    // 21 bytes ending in AB -> 6 words, last 32'hAB000000
    make_pkt(20, 8'h10);
    pkt.push_back(8'hAB);
    drive_pkt(1'b1, e);
    push_exp(e, 99);
    check_replay(6);

    // single-byte packet
    pkt = '{8'h7E};
    drive_pkt(1'b1, e);
    push_exp(e, 99);
    check_replay(1);

    // sof restart after 6 bytes, then 8-byte packet 01..08
    make_pkt(6, 8'hC0);
    drive_pkt(1'b0, e);
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    drive_pkt(1'b1, e);
    push_exp(e, 99);
    check_replay(2);
    last_len = 2;

    // overflow: 4*DEPTH_WORDS+1 bytes -> drop at E+1, no replay
    make_pkt(4*DEPTH_WORDS + 1, 8'h33);
    drive_pkt(1'b1, e);
    @(negedge clk);
    chk("drop_pulse", {63'h0, drop}, 64'h1);
    chk("drop_ready", {63'h0, in_ready}, 64'h1);
    chk("drop_busy", {63'h0, busy}, 64'h0);
    chk("drop_len_hold", 64'(len_words), 64'(last_len));
    @(negedge clk);
    chk("drop_one_cycle", {63'h0, drop}, 64'h0);

    // exactly full depth is legal
    make_pkt(4*DEPTH_WORDS, 8'h81);
    drive_pkt(1'b1, e);
    push_exp(e, 99);
    check_replay(DEPTH_WORDS);

    // reset during word 2 of a 5-word replay
    pkt = '{8'h45, 8'h00, 8'h00, 8'h14, 8'hde, 8'had, 8'hbe, 8'hef, 8'h11, 8'h22,
            8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc};
    drive_pkt(1'b1, e);
    push_exp(e, 2);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_valid", {63'h0, word_valid}, 64'h0);
    chk("abort_data", {32'h0, data}, 64'h0);
    chk("abort_busy", {63'h0, busy}, 64'h0);
    chk("abort_ready", {63'h0, in_ready}, 64'h1);
    chk("abort_len", 64'(len_words), 64'h0);
    @(negedge clk);
    chk("abort_queue", 64'(exp_q.size()), 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // replay after reset
    make_pkt(20, 8'h5A);
    pkt.push_back(8'hAB);
    drive_pkt(1'b1, e);
    push_exp(e, 99);
    check_replay(6);

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
